// File: rtl/encoder.sv
// rtl/encoder.sv - registered MSB-priority encoder with valid and non-one-hot error flags
//
// Ports:
//   clk   in   rising-edge clock for every register
//   rst   in   asynchronous active-high reset, clears all outputs
//   Y     in   [IN_W-1:0] request lines, Y[i] high = input i active
//   A     out  [OUT_W-1:0] registered index of the highest active request
//   valid out  registered, high when any request was active
//   err   out  registered, high when more than one request was active
module encoder #(
  parameter int IN_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_W-1:0]          Y,
  output logic [$clog2(IN_W)-1:0]  A,
  output logic                     valid,
  output logic                     err
);

  localparam int OUT_W = $clog2(IN_W);

  logic [OUT_W-1:0] a_d;
  logic [OUT_W-1:0] a_q;
  logic             valid_d;
  logic             valid_q;
  logic             err_d;
  logic             err_q;

  // Ascending scan: a later (higher) set bit overwrites the index, giving MSB
  // priority. "seen" is the OR of all bits so far; a set bit arriving once
  // "seen" is already high means the population count exceeds one, so err is
  // exact for any width without building a full adder tree.
  always_comb begin
    logic seen;
    logic multi;
    a_d   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (Y[i]) begin
        a_d   = OUT_W'(i);
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    valid_d = seen;
    err_d   = multi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign A     = a_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_encoder.sv
// tb/tb_encoder.sv - self-checking bench for the registered priority encoder
module tb_encoder;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic [3:0] Y;
  logic [1:0] A;
  logic       valid;
  logic       err;
  logic [3:0] out;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [3:0] y;
    logic [1:0] a;
    logic       v;
    logic       e;
  } vec_t;

  vec_t       vecs[12];
  logic [3:0] exp_q[$];

  encoder #(.IN_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .Y     (Y),
    .A     (A),
    .valid (valid),
    .err   (err)
  );

  assign out = {A, valid, err};

  // 20 ns period; the clock can be frozen (held low) through clk_en
  always begin
    #10;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got A/valid/err=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [3:0] model(input logic [3:0] y);
    logic [1:0] a;
    a = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (y[i]) begin
        a = 2'(i);
        break;
      end
    end
    return {a, |y, ($countones(y) > 1)};
  endfunction

  // Drive Y away from the edge, queue the expectation, compare after the edge
  task automatic step(input string name, input logic [3:0] y, input logic [3:0] exp);
    logic [3:0] e;
    @(negedge clk);
    Y = y;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got empty scoreboard expected entry", name);
    end else begin
      e = exp_q.pop_front();
      chk(name, out, e);
    end
  endtask

  initial begin
    logic [3:0] ry;
    n_chk  = 0;
    n_fail = 0;
    clk    = 1'b0;
    clk_en = 1'b1;
    rst    = 1'b1;
    Y      = 4'b1000;

    vecs[0]  = '{4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[2]  = '{4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[3]  = '{4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[4]  = '{4'b0110, 2'd2, 1'b1, 1'b1};
    vecs[5]  = '{4'b1011, 2'd3, 1'b1, 1'b1};
    vecs[6]  = '{4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{4'b1111, 2'd3, 1'b1, 1'b1};
    vecs[9]  = '{4'b0011, 2'd1, 1'b1, 1'b1};
    vecs[10] = '{4'b1100, 2'd3, 1'b1, 1'b1};
    vecs[11] = '{4'b0101, 2'd2, 1'b1, 1'b1};

    // reset held with an active request for three cycles
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", out, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d", i), vecs[i].y, {vecs[i].a, vecs[i].v, vecs[i].e});
    end

    for (int i = 0; i < 24; i++) begin
      ry = 4'($urandom_range(0, 15));
      step("random", ry, model(ry));
    end

    // glitch on Y between edges must not reach the outputs
    step("glitch_pre", 4'b1000, 4'b1110);
    #2;
    Y = 4'b0010;
    #2;
    chk("glitch_hold", out, 4'b1110);
    #2;
    Y = 4'b0001;
    #1;
    chk("glitch_restore", out, 4'b1110);
    @(posedge clk);
    #1;
    chk("glitch_edge", out, 4'b0010);

    // mid-run asynchronous reset while A=11, clock still running
    step("midrst_pre", 4'b1000, 4'b1110);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_async", out, 4'b0000);
    @(negedge clk);
    Y   = 4'b0100;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_release", out, 4'b1010);

    // reset with the clock frozen
    step("frozen_pre", 4'b1000, 4'b1110);
    @(negedge clk);
    clk_en = 1'b0;
    #5;
    rst = 1'b1;
    #1;
    chk("frozen_rst", out, 4'b0000);
    #30;
    chk("frozen_rst_hold", out, 4'b0000);
    Y   = 4'b0100;
    rst = 1'b0;
    #1;
    chk("frozen_release_noedge", out, 4'b0000);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("frozen_first_edge", out, 4'b1010);

    step("final_idle", 4'b0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
